// File: rtl/sfx_sequencer_pkg.sv
// sfx_pkg: shared types and constants for the sound-effect sequencer.
// Holds the FSM state enum, the default load/play lengths and the system
// clock frequency the play length was derived from.
package sfx_pkg;

  // Sequencer states; IDLE doubles as the mute/reset state.
  typedef enum logic [1:0] {
    IDLE,
    LOAD_HIT,
    LOAD_SCORE,
    PLAY
  } sfx_state_t;

  localparam int CLK_HZ          = 50_000_000;
  localparam int DEF_LOAD_CYCLES = 4;
  // Two 250 ms note units at CLK_HZ plus a small margin.
  localparam int DEF_PLAY_CYCLES = 25_000_010;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sfx_sequencer_if.sv
// sfx_sequencer_if: game-side event inputs and tone-generator control outputs
// of the sound-effect sequencer.
//   paddle_hit     game -> seq   one-cycle paddle chime request
//   brick_hit      game -> seq   one-cycle score jingle request
//   mute           game -> seq   level: silence and flush
//   music_en       seq  -> tone  1 = silent/load, 0 = play
//   Score_Music_En seq  -> tone  1 = load score notes
//   busy           seq  -> game  sequence running or event pending
//   drop_cnt       seq  -> game  saturating count of lost events
// master = game logic / bench side, slave = sequencer side.
interface sfx_sequencer_if #(
  parameter int DROP_W = 8
);
  logic              paddle_hit;
  logic              brick_hit;
  logic              mute;
  logic              music_en;
  logic              Score_Music_En;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output paddle_hit, brick_hit, mute,
    input  music_en, Score_Music_En, busy, drop_cnt
  );

  modport slave (
    input  paddle_hit, brick_hit, mute,
    output music_en, Score_Music_En, busy, drop_cnt
  );
endinterface

// File: rtl/sfx_sequencer_event_latch.sv
// sfx_event_latch: one pending-request flag for the sequencer.
//   clk, rst   clock and synchronous active-high reset
//   clr        flush (mute): clears the flag and suppresses drops
//   set        one-cycle event pulse
//   consume    the sequencer is starting a sequence for this event class
//   pend       registered pending flag
//   pend_nxt   value pend takes at the next edge (used for registered busy)
//   drop       combinational pulse: an event was lost this cycle
module sfx_event_latch (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic set,
  input  logic consume,
  output logic pend,
  output logic pend_nxt,
  output logic drop
);

  // A consume takes either the stored flag or, if nothing is stored, the
  // pulse itself. A pulse arriving while the stored flag is being taken
  // re-arms the flag instead of being lost.
  always_comb begin
    pend_nxt = 1'b0;
    if (!clr) begin
      if (consume) pend_nxt = pend & set;
      else         pend_nxt = pend | set;
    end
  end

  assign drop = set & pend & ~consume & ~clr;

  always_ff @(posedge clk) begin
    if (rst) pend <= 1'b0;
    else     pend <= pend_nxt;
  end

endmodule

// File: rtl/sfx_sequencer.sv
// sfx_sequencer: turns one-cycle game events into the load/play control
// sequence for the speaker tone generator.
//   clk   system clock (50 MHz)
//   rst   synchronous active-high reset
//   bus   sfx_sequencer_if.slave: paddle_hit, brick_hit, mute in;
//         music_en, Score_Music_En, busy, drop_cnt out (all registered)
// Parameters: LOAD_CYCLES (load hold), PLAY_CYCLES (play length),
// DROP_W (drop counter width).
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int LOAD_CYCLES = DEF_LOAD_CYCLES,
  parameter int PLAY_CYCLES = DEF_PLAY_CYCLES,
  parameter int DROP_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  sfx_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(max_int(LOAD_CYCLES, PLAY_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLAY_LAST = CNT_W'(PLAY_CYCLES - 1);

  sfx_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              music_en_q;
  logic              score_en_q;
  logic              busy_q;
  logic [DROP_W-1:0] drop_cnt_q;

  logic consume_hit, consume_score;
  logic pend_hit, pend_score, pend_hit_nxt, pend_score_nxt;
  logic drop_hit, drop_score;
  logic pend_any_nxt;

  logic [1:0]        drop_inc;
  logic [DROP_W:0]   drop_sum;

  // Arbitration: only IDLE starts a sequence, and score beats hit. The
  // losing request is left untouched in its latch.
  always_comb begin
    consume_hit   = 1'b0;
    consume_score = 1'b0;
    if (state == IDLE && !bus.mute) begin
      if (pend_score || bus.brick_hit)     consume_score = 1'b1;
      else if (pend_hit || bus.paddle_hit) consume_hit   = 1'b1;
    end
  end

  sfx_event_latch u_hit_latch (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.mute),
    .set      (bus.paddle_hit),
    .consume  (consume_hit),
    .pend     (pend_hit),
    .pend_nxt (pend_hit_nxt),
    .drop     (drop_hit)
  );

  sfx_event_latch u_score_latch (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.mute),
    .set      (bus.brick_hit),
    .consume  (consume_score),
    .pend     (pend_score),
    .pend_nxt (pend_score_nxt),
    .drop     (drop_score)
  );

  assign pend_any_nxt = pend_hit_nxt | pend_score_nxt;

  // FSM with outputs registered from the next state, so a request seen in
  // cycle k shows load outputs in cycle k+1. The counter restarts at 0 on
  // every state entry and stops at PARAM-1, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst || bus.mute) begin
      state      <= IDLE;
      cnt        <= '0;
      music_en_q <= 1'b1;
      score_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (consume_score) begin
            state      <= LOAD_SCORE;
            music_en_q <= 1'b1;
            score_en_q <= 1'b1;
            busy_q     <= 1'b1;
          end else if (consume_hit) begin
            state      <= LOAD_HIT;
            music_en_q <= 1'b1;
            score_en_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            music_en_q <= 1'b1;
            score_en_q <= 1'b0;
            busy_q     <= pend_any_nxt;
          end
        end
        LOAD_HIT, LOAD_SCORE: begin
          busy_q <= 1'b1;
          if (cnt == LOAD_LAST) begin
            state      <= PLAY;
            cnt        <= '0;
            music_en_q <= 1'b0;
            score_en_q <= 1'b0;
          end else begin
            cnt        <= cnt + 1'b1;
            music_en_q <= 1'b1;
            score_en_q <= (state == LOAD_SCORE);
          end
        end
        PLAY: begin
          music_en_q <= (cnt == PLAY_LAST);
          score_en_q <= 1'b0;
          if (cnt == PLAY_LAST) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= pend_any_nxt;
          end else begin
            cnt    <= cnt + 1'b1;
            busy_q <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          music_en_q <= 1'b1;
          score_en_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Both latches can drop in the same cycle; the extra top bit of the sum
  // flags overflow so the counter clamps at all-ones.
  assign drop_inc = {1'b0, drop_hit} + {1'b0, drop_score};
  assign drop_sum = {1'b0, drop_cnt_q} + (DROP_W+1)'(drop_inc);

  always_ff @(posedge clk) begin
    if (rst)                   drop_cnt_q <= '0;
    else if (drop_sum[DROP_W]) drop_cnt_q <= '1;
    else                       drop_cnt_q <= drop_sum[DROP_W-1:0];
  end

  assign bus.music_en       = music_en_q;
  assign bus.Score_Music_En = score_en_q;
  assign bus.busy           = busy_q;
  assign bus.drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb_sfx_sequencer: directed scenarios followed by random events, all checked
// cycle by cycle against a timeline model of the sequencer (a sequence is a
// start time plus a kind; outputs follow from the elapsed time).
module tb_sfx_sequencer;

  localparam int L    = 2;
  localparam int P    = 10;
  localparam int DW   = 8;
  localparam int DMAX = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sfx_sequencer_if #(.DROP_W(DW)) bus ();

  sfx_sequencer #(
    .LOAD_CYCLES (L),
    .PLAY_CYCLES (P),
    .DROP_W      (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int t        = 0;
  bit exp_valid = 1'b0;

  // Expected outputs for the next cycle.
  logic exp_music, exp_score, exp_busy;
  int   exp_drop;

  // Model state: current sequence (if any), pending requests, drop total.
  bit active, kind_score, mp_h, mp_s;
  int start, mdrop;

  task checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, t, actual, expected);
  endtask

  task add_drops(input int n);
    mdrop = (mdrop + n > DMAX) ? DMAX : mdrop + n;
  endtask

  // Advance the model by one cycle with the inputs present in cycle t and
  // derive the outputs expected in cycle t+1.
  task model_step(input logic r, input logic p, input logic b, input logic m);
    int e;
    if (r) begin
      active = 0; mp_h = 0; mp_s = 0; mdrop = 0;
    end else if (m) begin
      active = 0; mp_h = 0; mp_s = 0;
    end else begin
      if (active && t > start + L + P) active = 0;
      if (!active) begin
        if (mp_s || b) begin
          active = 1; kind_score = 1; start = t;
          mp_s = mp_s && b;
          if (p && mp_h) add_drops(1);
          mp_h = mp_h || p;
        end else if (mp_h || p) begin
          active = 1; kind_score = 0; start = t;
          mp_h = mp_h && p;
        end
      end else begin
        if (p && mp_h) add_drops(1);
        if (b && mp_s) add_drops(1);
        mp_h = mp_h || p;
        mp_s = mp_s || b;
      end
    end
    e = t + 1 - start;
    if (active && e <= L) begin
      exp_music = 1'b1; exp_score = kind_score;
    end else if (active && e <= L + P) begin
      exp_music = 1'b0; exp_score = 1'b0;
    end else begin
      exp_music = 1'b1; exp_score = 1'b0;
    end
    exp_busy = (active && e <= L + P) || mp_h || mp_s;
    exp_drop = mdrop;
  endtask

  // One cycle: check the outputs settled from the last edge, then drive the
  // inputs for the coming edge and update the model.
  task applyStimulus(input logic r, input logic p, input logic b, input logic m);
    @(negedge clk);
    if (exp_valid) begin
      checkOutput("music_en", bus.music_en, exp_music);
      checkOutput("Score_Music_En", bus.Score_Music_En, exp_score);
      checkOutput("busy", bus.busy, exp_busy);
      checkOutput("drop_cnt", bus.drop_cnt, exp_drop);
    end
    rst = r;
    bus.paddle_hit = p;
    bus.brick_hit  = b;
    bus.mute       = m;
    model_step(r, p, b, m);
    exp_valid = 1'b1;
    t++;
  endtask

  task idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic mute_lvl;
  logic rr, rp, rb;

  initial begin
    bus.paddle_hit = 1'b0;
    bus.brick_hit  = 1'b0;
    bus.mute       = 1'b0;
    active = 0; kind_score = 0; mp_h = 0; mp_s = 0; start = 0; mdrop = 0;

    $display("[TB] reset and idle");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);

    $display("[TB] single paddle hit");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(15);

    $display("[TB] simultaneous brick and paddle");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    idle(30);

    $display("[TB] three paddle hits during play");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    repeat (3) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
    end
    idle(30);
    checkOutput("drops_after_play_hits", bus.drop_cnt, 2);

    $display("[TB] mute during play with score pending");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mute_busy", bus.busy, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("mute_no_drop", bus.drop_cnt, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idle(15);

    $display("[TB] drop saturation");
    repeat (200) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    checkOutput("drop_saturated", bus.drop_cnt, DMAX);
    idle(30);

    $display("[TB] reset during score load");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_music_en", bus.music_en, 1);
    checkOutput("rst_score_en", bus.Score_Music_En, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_drop_cnt", bus.drop_cnt, 0);

    $display("[TB] random events");
    mute_lvl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 79) == 0) mute_lvl = ~mute_lvl;
      rr = ($urandom_range(0, 499) == 0);
      rp = ($urandom_range(0, 7) == 0);
      rb = ($urandom_range(0, 9) == 0);
      applyStimulus(rr, rp, rb, mute_lvl);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
